// File: rtl/parity_pkg.sv
// Shared types, line levels and the parity helper for the parity serial transmitter.
package parity_pkg;

   // Widest data word the transmitter supports; parity helper operates at this width.
   localparam int unsigned MAX_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Even parity is the XOR of all bits; odd parity inverts it. Zero-extension is harmless.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator.
//   data_i   : word whose parity is computed
//   parity_o : ^data_i, inverted when PARITY_ODD is set
module parity_calc
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic [DATA_W-1:0] data_i,
   output logic              parity_o
);

   localparam logic ODD = (PARITY_ODD != 0);

   assign parity_o = calc_parity(MAX_DATA_W'(data_i), ODD);

endmodule

// File: rtl/parity_serial_tx.sv
// Parity serial transmitter: accepts a word on a valid/ready handshake and sends
// start(0), data LSB first, parity, stop(1), each bit held for BAUD_DIV clocks.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : word to send, sampled only on the accept edge
//   in_valid   : producer has a word
//   in_ready   : combinational, high exactly in IDLE
//   tx_out     : registered serial line, idles high
//   busy       : registered, high for the whole frame
//   frame_done : registered one-cycle pulse in the first IDLE cycle after a frame
module parity_serial_tx
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned BAUD_DIV   = 4,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              par_c;
   logic              baud_wrap;

   // Parity of the word on the input bus; only latched on the accept edge.
   parity_calc #(
      .DATA_W     (DATA_W),
      .PARITY_ODD (PARITY_ODD)
   ) u_parity_calc (
      .data_i   (in_data),
      .parity_o (par_c)
   );

   assign baud_wrap = (baud_q == BAUD_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      // Every non-idle state times its bit with the same baud counter.
      if (state_q != IDLE) begin
         baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shift_d = in_data;
               par_d   = par_c;
               state_d = START;
               tx_d    = START_BIT;
               busy_d  = 1'b1;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         START: begin
            if (baud_wrap) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_q == BIT_LAST) begin
                  state_d = PARITY;
                  tx_d    = par_q;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BIT_W'(1);
                  tx_d    = shift_d[0];
               end
            end
         end
         PARITY: begin
            if (baud_wrap) begin
               state_d = STOP;
               tx_d    = STOP_BIT;
            end
         end
         STOP: begin
            if (baud_wrap) begin
               state_d = IDLE;
               tx_d    = IDLE_LEVEL;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign in_ready   = (state_q == IDLE);
   assign tx_out     = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench: even and odd parity 4-bit/4-clock instances plus an 8-bit/1-clock instance.
module tb_parity_serial_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] d0, d1;
   logic       v0, v1, r0, r1, t0, t1, b0, b1, f0, f1;
   logic [7:0] d2;
   logic       v2, r2, t2, b2, f2;

   int n_tests = 0;
   int n_fail  = 0;

   parity_serial_tx #(.DATA_W(4), .BAUD_DIV(4), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0),
      .in_ready(r0), .tx_out(t0), .busy(b0), .frame_done(f0));

   parity_serial_tx #(.DATA_W(4), .BAUD_DIV(4), .PARITY_ODD(1)) dut_odd (
      .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1),
      .in_ready(r1), .tx_out(t1), .busy(b1), .frame_done(f1));

   parity_serial_tx #(.DATA_W(8), .BAUD_DIV(1), .PARITY_ODD(0)) dut_b1 (
      .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2),
      .in_ready(r2), .tx_out(t2), .busy(b2), .frame_done(f2));

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic [3:0] d);
      if (sel) begin v1 = v; d1 = d; end
      else     begin v0 = v; d0 = d; end
   endtask

   // {in_ready, tx_out, busy, frame_done} of the selected 4-bit instance
   function automatic logic [3:0] obs(input bit sel);
      return sel ? {r1, t1, b1, f1} : {r0, t0, b0, f0};
   endfunction

   // Sends one word from a negedge; returns at the negedge of the first IDLE cycle.
   task automatic frame4(input bit sel, input logic [3:0] w, input logic par,
                         input bit b2b, input logic [3:0] nxt, input string tag);
      logic [6:0] bits;
      logic [3:0] o;
      int busy_n, rdy_lo, done_n;
      bits   = {1'b1, par, w, 1'b0};
      busy_n = 0;
      rdy_lo = 0;
      done_n = 0;
      drive(sel, 1'b1, w);
      #1;
      o = obs(sel);
      check({tag, " ready_before"}, 8'(o[3]), 8'd1);
      @(posedge clk);
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (b2b) drive(sel, 1'b1, nxt);
            else     drive(sel, 1'b0, 4'bxxxx);
         end
         o = obs(sel);
         if (o[1] === 1'b1) busy_n++;
         if (o[3] === 1'b0) rdy_lo++;
         if (o[0] !== 1'b0) done_n++;
         if (k % 4 == 3) check($sformatf("%s bit%0d", tag, k / 4), 8'(o[2]), 8'(bits[k / 4]));
      end
      check({tag, " busy_cycles"}, 8'(busy_n), 8'd28);
      check({tag, " ready_low_cycles"}, 8'(rdy_lo), 8'd28);
      check({tag, " early_done"}, 8'(done_n), 8'd0);
      @(negedge clk);
      o = obs(sel);
      check({tag, " done_pulse"}, 8'(o[0]), 8'd1);
      check({tag, " busy_end"}, 8'(o[1]), 8'd0);
      check({tag, " ready_end"}, 8'(o[3]), 8'd1);
      check({tag, " idle_line"}, 8'(o[2]), 8'd1);
   endtask

   initial begin
      logic [10:0] exp_b1;
      v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0; v2 = 1'b0; d2 = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst tx", 8'(t0), 8'd1);
      check("rst busy", 8'(b0), 8'd0);
      check("rst done", 8'(f0), 8'd0);
      check("rst ready", 8'(r0), 8'd1);
      check("rst tx_odd", 8'(t1), 8'd1);
      check("rst tx_b1", 8'(t2), 8'd1);
      check("rst ready_b1", 8'(r2), 8'd1);
      rst = 1'b0;
      @(negedge clk);

      // Even parity words
      frame4(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, "w0000");
      @(negedge clk);
      check("w0000 done_cleared", 8'(f0), 8'd0);
      frame4(1'b0, 4'b0111, 1'b1, 1'b0, 4'b0000, "w0111");
      @(negedge clk);
      frame4(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, "w1111");
      @(negedge clk);
      frame4(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, "w0001");
      @(negedge clk);

      // Odd parity words
      frame4(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, "odd0000");
      @(negedge clk);
      frame4(1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, "odd0011");
      @(negedge clk);

      // Back-to-back with in_valid held; in_data switches to the next word mid-frame
      frame4(1'b0, 4'b1010, 1'b0, 1'b1, 4'b0101, "b2b_a");
      frame4(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, "b2b_b");
      @(negedge clk);

      // Reset in cycle 10 of a frame (data bit 1 of 0101 is 0 on the line)
      drive(1'b0, 1'b1, 4'b0101);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'b0000);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      check("midrst line_before", 8'(t0), 8'd0);
      #1 rst = 1'b1;
      #1;
      check("midrst tx", 8'(t0), 8'd1);
      check("midrst busy", 8'(b0), 8'd0);
      check("midrst ready", 8'(r0), 8'd1);
      check("midrst done", 8'(f0), 8'd0);
      drive(1'b0, 1'b1, 4'b0001);
      @(negedge clk);
      check("midrst done_hold1", 8'(f0), 8'd0);
      @(negedge clk);
      check("midrst done_hold2", 8'(f0), 8'd0);
      check("midrst tx_hold", 8'(t0), 8'd1);
      rst = 1'b0;
      frame4(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, "postrst");
      @(negedge clk);

      // BAUD_DIV=1, DATA_W=8, word A5: start, A5 LSB first, parity 0, stop
      exp_b1 = {1'b1, 1'b0, 8'hA5, 1'b0};
      d2 = 8'hA5;
      v2 = 1'b1;
      #1;
      check("b1 ready", 8'(r2), 8'd1);
      @(posedge clk);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 1) begin
            v2 = 1'b0;
            d2 = 8'hxx;
         end
         check($sformatf("b1 bit%0d", k - 1), 8'(t2), 8'(exp_b1[k - 1]));
         check($sformatf("b1 busy%0d", k - 1), 8'(b2), 8'd1);
      end
      @(negedge clk);
      check("b1 done", 8'(f2), 8'd1);
      check("b1 busy_end", 8'(b2), 8'd0);
      check("b1 idle_line", 8'(t2), 8'd1);
      @(negedge clk);
      check("b1 done_cleared", 8'(f2), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
